// File: rtl/ecc_scrub_writeback.sv
// Scrub write-back queue: captures single-error-corrected loads and rewrites them to the
// cache data array through a req/gnt port; also keeps CE/UE event counters.
module ecc_scrub_writeback #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [6:0]        ld_parity,
  input  logic              ld_single_error,
  input  logic              ld_double_error,
  input  logic              store_valid,
  input  logic [ADDR_W-1:0] store_addr,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic [6:0]        wb_parity,
  input  logic              wb_gnt,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic              overflow,
  output logic              busy
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [31:0]         data_q [DEPTH];
  logic [6:0]          par_q  [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]    ce_q, ce_d, ue_q, ue_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [6:0]          wb_par_q, wb_par_d;

  logic ce_s, ue_s, store_hit_ld_s, dup_s, full_s, push_s, pop_s;
  logic non_empty_s, head_valid_s, head_kill_s, wb_req_s;

  assign ce_s           = ld_valid && ld_single_error && !ld_double_error;
  assign ue_s           = ld_valid && ld_double_error;
  assign store_hit_ld_s = store_valid && (store_addr == ld_addr);
  assign full_s         = (count_q == COUNT_W'(DEPTH));
  assign non_empty_s    = (count_q != {COUNT_W{1'b0}});
  assign head_valid_s   = non_empty_s && valid_q[rd_ptr_q];
  // A same-cycle store to the head address carries fresh data, so it kills the request.
  assign head_kill_s    = store_valid && (store_addr == addr_q[rd_ptr_q]);
  assign wb_req_s       = (state_q == ST_REQ) && head_valid_s && !head_kill_s;
  assign push_s         = ce_s && !store_hit_ld_s && !dup_s && !full_s;

  // Duplicate detection against every live entry
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
  end

  // Write-back FSM next state and head pop decision
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_valid_s) begin
          state_d = ST_REQ;
        end else if (non_empty_s) begin
          pop_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (wb_req_s && wb_gnt) begin
          pop_s   = 1'b1;
          state_d = ST_IDLE;
        end else if (!wb_req_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue bookkeeping: invalidate on store, clear on pop, set on push
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (store_valid && valid_q[i] && (addr_q[i] == store_addr)) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_d[i];
      end
    end
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (push_s) begin
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Saturating counters, sticky overflow and registered write-back payload
  always_comb begin
    ce_d       = ce_q;
    ue_d       = ue_q;
    overflow_d = overflow_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_par_d   = wb_par_q;
    if (ce_s && (ce_q != {CNT_W{1'b1}})) begin
      ce_d = ce_q + CNT_W'(1);
    end else begin
      ce_d = ce_q;
    end
    if (ue_s && (ue_q != {CNT_W{1'b1}})) begin
      ue_d = ue_q + CNT_W'(1);
    end else begin
      ue_d = ue_q;
    end
    if (ce_s && !store_hit_ld_s && !dup_s && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
      wb_addr_d = addr_q[rd_ptr_q];
      wb_data_d = data_q[rd_ptr_q];
      wb_par_d  = par_q[rd_ptr_q];
    end else if ((state_q == ST_REQ) && (state_d == ST_IDLE)) begin
      wb_addr_d = {ADDR_W{1'b0}};
      wb_data_d = 32'h0000_0000;
      wb_par_d  = 7'h00;
    end else begin
      wb_addr_d = wb_addr_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      valid_q    <= {DEPTH{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {COUNT_W{1'b0}};
      ce_q       <= {CNT_W{1'b0}};
      ue_q       <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
      wb_addr_q  <= {ADDR_W{1'b0}};
      wb_data_q  <= 32'h0000_0000;
      wb_par_q   <= 7'h00;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        data_q[i] <= 32'h0000_0000;
        par_q[i]  <= 7'h00;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ce_q       <= ce_d;
      ue_q       <= ue_d;
      overflow_q <= overflow_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_par_q   <= wb_par_d;
      if (push_s) begin
        addr_q[wr_ptr_q] <= ld_addr;
        data_q[wr_ptr_q] <= ld_data;
        par_q[wr_ptr_q]  <= ld_parity;
      end
    end
  end

  assign wb_req    = wb_req_s;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign wb_parity = wb_par_q;
  assign ce_count  = ce_q;
  assign ue_count  = ue_q;
  assign overflow  = overflow_q;
  assign busy      = non_empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ecc_scrub_writeback.sv
// Bench for ecc_scrub_writeback: directed scenarios plus randomized traffic against a
// queue-based reference model of the scrub behaviour.
module tb_ecc_scrub_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid, ld_single_error, ld_double_error, store_valid, wb_gnt;
  logic [9:0]  ld_addr, store_addr;
  logic [31:0] ld_data;
  logic [6:0]  ld_parity;
  logic        wb_req, overflow, busy;
  logic [9:0]  wb_addr;
  logic [31:0] wb_data;
  logic [6:0]  wb_parity;
  logic [15:0] ce_count, ue_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecc_scrub_writeback #(.ADDR_W(10), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_parity(ld_parity),
    .ld_single_error(ld_single_error), .ld_double_error(ld_double_error),
    .store_valid(store_valid), .store_addr(store_addr),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_parity(wb_parity),
    .wb_gnt(wb_gnt), .ce_count(ce_count), .ue_count(ue_count),
    .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [6:0]  par;
    bit          valid;
  } ent_t;

  ent_t        mq[$];
  bit          m_req;
  int unsigned m_ce, m_ue;
  bit          m_ovf;
  logic [9:0]  dut_wr[$];

  function automatic bit exp_req();
    return m_req && (mq.size() > 0) && mq[0].valid &&
           !(store_valid && (store_addr == mq[0].addr));
  endfunction

  function automatic bit exp_busy();
    return (mq.size() != 0) || m_req;
  endfunction

  task automatic model_update();
    bit r, pop, nreq, ce, dup, shit, push;
    ent_t e;
    if (!reset_n) begin
      mq.delete();
      m_req = 1'b0; m_ce = 0; m_ue = 0; m_ovf = 1'b0;
      return;
    end
    r    = exp_req();
    ce   = ld_valid && ld_single_error && !ld_double_error;
    shit = store_valid && (store_addr == ld_addr);
    dup  = 1'b0;
    foreach (mq[i]) if (mq[i].valid && mq[i].addr == ld_addr) dup = 1'b1;
    if (m_req) begin
      pop  = r && wb_gnt;
      nreq = r && !wb_gnt;
    end else begin
      pop  = (mq.size() > 0) && !mq[0].valid;
      nreq = (mq.size() > 0) && mq[0].valid;
    end
    if (ce && m_ce != 65535) m_ce++;
    if (ld_valid && ld_double_error && m_ue != 65535) m_ue++;
    push = ce && !shit && !dup && (mq.size() < DEPTH);
    if (ce && !shit && !dup && mq.size() == DEPTH) m_ovf = 1'b1;
    if (store_valid) foreach (mq[i]) if (mq[i].addr == store_addr) mq[i].valid = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.addr = ld_addr; e.data = ld_data; e.par = ld_parity; e.valid = 1'b1;
      mq.push_back(e);
    end
    m_req = nreq;
  endtask

  task automatic step();
    if (wb_req === 1'b1 && wb_gnt === 1'b1) dut_wr.push_back(wb_addr);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_single_error = 1'b0; ld_double_error = 1'b0;
    ld_addr = 10'h000; ld_data = 32'h0; ld_parity = 7'h00;
    store_valid = 1'b0; store_addr = 10'h000;
  endtask

  task automatic reset_dut();
    idle_inputs();
    wb_gnt = 1'b0;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    dut_wr.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    wb_gnt = 1'b1;
    reset_n = 1'b0;
    step(); step();
    #1;
    checks++;
    if ({wb_req, wb_addr, wb_data, wb_parity} !== 50'h0) begin
      errors++;
      $display("FAIL reset_wb: got req=%b addr=%h data=%h par=%h, want all 0", wb_req, wb_addr, wb_data, wb_parity);
    end
    checks++;
    if ({ce_count, ue_count, overflow, busy} !== 34'h0) begin
      errors++;
      $display("FAIL reset_status: got ce=%h ue=%h ovf=%b busy=%b, want all 0", ce_count, ue_count, overflow, busy);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (wb_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_gnt_empty: cycle %0d wb_req=%b, want 0", i, wb_req);
      end
    end
  endtask

  task automatic test_single_ce();
    reset_dut();
    wb_gnt = 1'b1;
    ld_valid = 1'b1; ld_single_error = 1'b1;
    ld_addr = 10'h055; ld_data = 32'hDEADBEEF; ld_parity = 7'h3A;
    #1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (wb_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_n1: got req=%b busy=%b, want req=0 busy=1", wb_req, busy);
    end
    step();
    #1;
    checks++;
    if (wb_req !== 1'b1 || wb_addr !== 10'h055 || wb_data !== 32'hDEADBEEF || wb_parity !== 7'h3A) begin
      errors++;
      $display("FAIL single_n2: got req=%b addr=%h data=%h par=%h, want 1 055 deadbeef 3a", wb_req, wb_addr, wb_data, wb_parity);
    end
    step();
    #1;
    checks++;
    if (wb_req !== 1'b0 || busy !== 1'b0 || ce_count !== 16'd1) begin
      errors++;
      $display("FAIL single_n3: got req=%b busy=%b ce=%0d, want 0 0 1", wb_req, busy, ce_count);
    end
    step();
    #1;
    checks++;
    if (wb_req !== exp_req() || dut_wr.size() != 1) begin
      errors++;
      $display("FAIL single_once: got req=%b writes=%0d, want req=%b writes=1", wb_req, dut_wr.size(), exp_req());
    end
  endtask

  task automatic test_overflow();
    logic [9:0] a[5];
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      a[i] = 10'(256 + 3 * i);
      ld_valid = 1'b1; ld_single_error = 1'b1; ld_addr = a[i];
      ld_data = $urandom; ld_parity = 7'($urandom_range(0, 127));
      #1;
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (overflow !== 1'b1 || ce_count !== 16'd5 || busy !== 1'b1 || wb_req !== 1'b1 || wb_addr !== a[0]) begin
      errors++;
      $display("FAIL ovf_state: got ovf=%b ce=%0d busy=%b req=%b addr=%h, want 1 5 1 1 %h", overflow, ce_count, busy, wb_req, wb_addr, a[0]);
    end
    wb_gnt = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (wb_req !== exp_req() || (exp_req() && {wb_addr, wb_data, wb_parity} !== {mq[0].addr, mq[0].data, mq[0].par})) begin
        errors++;
        $display("FAIL ovf_drain: cycle %0d req=%b addr=%h, want req=%b", c, wb_req, wb_addr, exp_req());
      end
      step();
    end
    checks++;
    if (dut_wr.size() != 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d write-backs, want 4", dut_wr.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= dut_wr.size() || dut_wr[k] !== a[k]) begin
        errors++;
        $display("FAIL ovf_order: write %0d addr=%h, want %h", k, (k < dut_wr.size()) ? dut_wr[k] : 10'h3FF, a[k]);
      end
    end
  endtask

  task automatic test_dup_store();
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_single_error = 1'b1; ld_addr = 10'h010;
      ld_data = 32'h1234_5678; ld_parity = 7'h11;
      #1;
      step();
    end
    idle_inputs();
    step(); step();
    store_valid = 1'b1; store_addr = 10'h010;
    #1;
    checks++;
    if (wb_req !== 1'b0 || ce_count !== 16'd2) begin
      errors++;
      $display("FAIL dup_kill: got req=%b ce=%0d, want 0 2", wb_req, ce_count);
    end
    step();
    idle_inputs();
    wb_gnt = 1'b1;
    for (int c = 0; c < 8; c++) step();
    #1;
    checks++;
    if (dut_wr.size() != 0 || busy !== 1'b0 || ce_count !== 16'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dup_result: got writes=%0d busy=%b ce=%0d ovf=%b, want 0 0 2 0", dut_wr.size(), busy, ce_count, overflow);
    end
  endtask

  task automatic test_kill_at_grant();
    reset_dut();
    ld_valid = 1'b1; ld_single_error = 1'b1; ld_addr = 10'h2A0;
    ld_data = 32'hCAFE_F00D; ld_parity = 7'h55;
    #1;
    step();
    idle_inputs();
    step(); step();
    #1;
    checks++;
    if (wb_req !== 1'b1 || wb_addr !== 10'h2A0) begin
      errors++;
      $display("FAIL kill_pre: got req=%b addr=%h, want 1 2a0", wb_req, wb_addr);
    end
    store_valid = 1'b1; store_addr = 10'h2A0; wb_gnt = 1'b1;
    #1;
    checks++;
    if (wb_req !== 1'b0) begin
      errors++;
      $display("FAIL kill_same_cycle: got wb_req=%b, want 0", wb_req);
    end
    step();
    idle_inputs();
    for (int c = 0; c < 6; c++) step();
    #1;
    checks++;
    if (dut_wr.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_result: got writes=%0d busy=%b, want 0 0", dut_wr.size(), busy);
    end
  endtask

  task automatic test_ded_saturate();
    reset_dut();
    wb_gnt = 1'b1;
    ld_valid = 1'b1; ld_double_error = 1'b1; ld_addr = 10'h3FF;
    #1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (ue_count !== 16'd1 || ce_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ded: got ue=%0d ce=%0d busy=%b, want 1 0 0", ue_count, ce_count, busy);
    end
    ld_valid = 1'b1; ld_single_error = 1'b1; ld_addr = 10'h001;
    store_valid = 1'b1; store_addr = 10'h001;
    for (int i = 0; i < 65535; i++) step();
    idle_inputs();
    #1;
    checks++;
    if (ce_count !== 16'hFFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL sat_reach: got ce=%h busy=%b, want ffff 0", ce_count, busy);
    end
    ld_valid = 1'b1; ld_single_error = 1'b1; ld_addr = 10'h002;
    #1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (ce_count !== 16'hFFFF || ce_count !== 16'(m_ce) || ue_count !== 16'd1) begin
      errors++;
      $display("FAIL sat_hold: got ce=%h ue=%0d, want ffff 1", ce_count, ue_count);
    end
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_random();
    int r;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      ld_valid = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 9);
      ld_single_error = (r < 6) || (r == 8);
      ld_double_error = (r >= 8);
      ld_addr = 10'($urandom_range(0, 7));
      ld_data = $urandom;
      ld_parity = 7'($urandom_range(0, 127));
      store_valid = ($urandom_range(0, 5) == 0);
      store_addr = 10'($urandom_range(0, 7));
      wb_gnt = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (wb_req !== exp_req() ||
          (exp_req() && {wb_addr, wb_data, wb_parity} !== {mq[0].addr, mq[0].data, mq[0].par})) begin
        errors++;
        $display("FAIL rand_wb: cycle %0d req=%b addr=%h data=%h, want req=%b", c, wb_req, wb_addr, wb_data, exp_req());
      end
      checks++;
      if (ce_count !== 16'(m_ce) || ue_count !== 16'(m_ue) || overflow !== m_ovf || busy !== exp_busy()) begin
        errors++;
        $display("FAIL rand_status: cycle %0d ce=%0d ue=%0d ovf=%b busy=%b, want %0d %0d %b %b",
                 c, ce_count, ue_count, overflow, busy, m_ce, m_ue, m_ovf, exp_busy());
      end
      step();
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    wb_gnt = 1'b0;
    reset_n = 1'b0;
    m_req = 1'b0; m_ce = 0; m_ue = 0; m_ovf = 1'b0;
    test_reset();
    test_single_ce();
    test_overflow();
    test_dup_store();
    test_kill_at_grant();
    test_random();
    test_ded_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
